// File: rtl/switch_mcu_regfile.sv
// Dual-read, single-write register file with an always-on debug peek port.
// Entry 0 is hardwired to zero; reads are registered with write-first bypass.
module switch_mcu_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_ren_1,
  input  logic [ADDR_W-1:0] in_raddr_1,
  output logic [DATA_W-1:0] out_rdata_1,
  input  logic              in_ren_2,
  input  logic [ADDR_W-1:0] in_raddr_2,
  output logic [DATA_W-1:0] out_rdata_2,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [ADDR_W-1:0] in_dbg_addr,
  output logic [DATA_W-1:0] out_dbg_data,
  output logic [15:0]       out_wr_cnt
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic [DATA_W-1:0] dbg_q, dbg_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              wr_commit;

  assign wr_commit = in_wen && (in_waddr != '0);

  // Zero index masks to 0; a same-edge committed write wins over stored data.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == '0)
      return '0;
    else if (wr_commit && (addr == in_waddr))
      return in_wdata;
    else
      return regs_q[addr];
  endfunction

  always_comb begin
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    dbg_d    = read_port(in_dbg_addr);
    wr_cnt_d = wr_cnt_q + 16'(wr_commit);
    if (in_ren_1) rdata1_d = read_port(in_raddr_1);
    if (in_ren_2) rdata2_d = read_port(in_raddr_2);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      dbg_q    <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (wr_commit) regs_q[in_waddr] <= in_wdata;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      dbg_q    <= dbg_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign out_rdata_1  = rdata1_q;
  assign out_rdata_2  = rdata2_q;
  assign out_dbg_data = dbg_q;
  assign out_wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// Randomized and directed bench for switch_mcu_regfile against a behavioural model.
module tb_switch_mcu_regfile;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_ren_1 = 1'b0, in_ren_2 = 1'b0, in_wen = 1'b0;
  logic [4:0]  in_raddr_1 = '0, in_raddr_2 = '0, in_waddr = '0, in_dbg_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [31:0] out_rdata_1, out_rdata_2, out_dbg_data;
  logic [15:0] out_wr_cnt;

  switch_mcu_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_ren_1(in_ren_1), .in_raddr_1(in_raddr_1), .out_rdata_1(out_rdata_1),
    .in_ren_2(in_ren_2), .in_raddr_2(in_raddr_2), .out_rdata_2(out_rdata_2),
    .in_wen(in_wen), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .in_dbg_addr(in_dbg_addr), .out_dbg_data(out_dbg_data), .out_wr_cnt(out_wr_cnt)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state: register contents and what each output must show.
  logic [31:0] m_mem [32];
  logic [31:0] m_r1 = '0, m_r2 = '0, m_dbg = '0;
  logic [15:0] m_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (in_wen && in_waddr != 0 && in_waddr == a) return in_wdata;
    return m_mem[a];
  endfunction

  // Drive one cycle of inputs; model advances right after the edge.
  task automatic cyc(input logic rst, input logic r1, input logic [4:0] a1,
                     input logic r2, input logic [4:0] a2,
                     input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] da);
    logic [31:0] e1, e2, ed;
    in_rst = rst; in_ren_1 = r1; in_raddr_1 = a1; in_ren_2 = r2; in_raddr_2 = a2;
    in_wen = w; in_waddr = wa; in_wdata = wd; in_dbg_addr = da;
    e1 = r1 ? m_read(a1) : m_r1;
    e2 = r2 ? m_read(a2) : m_r2;
    ed = m_read(da);
    @(posedge in_clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_r1 = '0; m_r2 = '0; m_dbg = '0; m_cnt = '0;
    end else begin
      m_r1 = e1; m_r2 = e2; m_dbg = ed;
      if (w && wa != 0) begin
        m_mem[wa] = wd;
        m_cnt = m_cnt + 16'd1;
      end
    end
    chk_en = 1'b1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
  endtask

  // Single compare process: every negedge once the model is meaningful.
  always @(negedge in_clk) begin
    if (chk_en) begin
      check("rdata_1", out_rdata_1, m_r1);
      check("rdata_2", out_rdata_2, m_r2);
      check("dbg_data", out_dbg_data, m_dbg);
      check("wr_cnt", {16'h0, out_wr_cnt}, {16'h0, m_cnt});
    end
  end

  initial begin
    logic [4:0] a;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
    cyc(1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 32'hFFFF_FFFF, 5'd9);
    @(negedge in_clk);
    check("reset_rdata_1", out_rdata_1, 32'h0);
    check("reset_wr_cnt", {16'h0, out_wr_cnt}, 32'h0);

    // All indices read zero after reset on both ports and debug.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b1, 5'(i), 1'b1, 5'(31 - i), 1'b0, 5'd0, 32'h0, 5'(i));
      @(negedge in_clk);
      check("post_reset_rd1", out_rdata_1, 32'h0);
      check("post_reset_rd2", out_rdata_2, 32'h0);
    end

    // Write 5, then read it a cycle later.
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0);
    cyc(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
    @(negedge in_clk);
    check("idx5_rd1", out_rdata_1, 32'hDEAD_BEEF);
    check("idx5_cnt", {16'h0, out_wr_cnt}, 32'd1);

    // Write to index 0 is dropped.
    cyc(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h1234_5678, 5'd0);
    @(negedge in_clk);
    check("idx0_rd1", out_rdata_1, 32'h0);
    check("idx0_rd2", out_rdata_2, 32'h0);
    check("idx0_dbg", out_dbg_data, 32'h0);
    check("idx0_cnt", {16'h0, out_wr_cnt}, 32'd1);

    // Write-first bypass on port 2 and debug.
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7);
    @(negedge in_clk);
    check("bypass_rd2", out_rdata_2, 32'hA5A5_A5A5);
    check("bypass_dbg", out_dbg_data, 32'hA5A5_A5A5);
    check("bypass_cnt", {16'h0, out_wr_cnt}, 32'd2);

    // Hold without ren while the entry changes underneath.
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h11, 5'd0);
    cyc(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
    cyc(1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b1, 5'd3, 32'h22, 5'd0);
    @(negedge in_clk);
    check("hold_rd1_a", out_rdata_1, 32'h11);
    idle();
    @(negedge in_clk);
    check("hold_rd1_b", out_rdata_1, 32'h11);
    cyc(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
    @(negedge in_clk);
    check("hold_rd1_new", out_rdata_1, 32'h22);

    // Randomized traffic, biased toward address collisions and rare resets.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 99) == 0),
          1'($urandom), ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
          1'($urandom), ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
          ($urandom_range(0, 2) != 0), wa, $urandom,
          ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
    end

    // Counter wrap: 65537 committed writes from a clean state leave 1.
    cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
    for (int n = 0; n < 65537; n++)
      cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom));
    @(negedge in_clk);
    check("wrap_cnt", {16'h0, out_wr_cnt}, 32'd1);

    // Reset with a concurrent write: everything zero, write lost.
    a = 5'd12;
    cyc(1'b0, 1'b1, a, 1'b1, a, 1'b1, a, 32'hCAFE_F00D, a);
    cyc(1'b1, 1'b1, a, 1'b1, a, 1'b1, a, 32'h5555_AAAA, a);
    @(negedge in_clk);
    check("rst_rd1", out_rdata_1, 32'h0);
    check("rst_dbg", out_dbg_data, 32'h0);
    check("rst_cnt", {16'h0, out_wr_cnt}, 32'd0);
    cyc(1'b0, 1'b1, a, 1'b1, a, 1'b0, 5'd0, 32'h0, a);
    @(negedge in_clk);
    check("rst_lost_rd1", out_rdata_1, 32'h0);
    check("rst_lost_rd2", out_rdata_2, 32'h0);
    check("rst_lost_dbg", out_dbg_data, 32'h0);

    @(negedge in_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
